// File: rtl/umi_req_arbiter.sv
// umi_req_arbiter: N:1 UMI request arbiter with round-robin selection,
// packet lock (grant held until the EOM beat) and a single registered
// output stage.
// Optional build macro: UMI_REQ_ARB_QOS_EN selects the unlocked winner by the
// highest cmd[19:16]. Ties among equal QoS go round-robin from rr_ptr.
module umi_req_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 32,
  parameter int unsigned AW = 64,
  parameter int unsigned DW = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    in_valid,
  input  logic [N*CW-1:0] in_cmd,
  input  logic [N*AW-1:0] in_dstaddr,
  input  logic [N*AW-1:0] in_srcaddr,
  input  logic [N*DW-1:0] in_data,
  output logic [N-1:0]    in_ready,
  input  logic [N-1:0]    arb_mask,
  output logic            out_valid,
  output logic [CW-1:0]   out_cmd,
  output logic [AW-1:0]   out_dstaddr,
  output logic [AW-1:0]   out_srcaddr,
  output logic [DW-1:0]   out_data,
  input  logic            out_ready,
  output logic [N-1:0]    out_grant
);

  localparam int unsigned IW      = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned EOM_BIT = 22;
`ifdef UMI_REQ_ARB_QOS_EN
  localparam int unsigned QOS_LSB = 16;
  localparam int unsigned QW      = 4;
`endif

  logic          lock;
  logic [IW-1:0] owner;
  logic [IW-1:0] rr_ptr;

  logic          slot_free;
  logic [N-1:0]  eligible;
  logic [IW-1:0] sel;
  logic          sel_vld;
  logic [IW-1:0] sel_next;
  logic          accept;
  logic          sel_eom;

  logic [CW-1:0] sel_cmd;
  logic [AW-1:0] sel_dstaddr;
  logic [AW-1:0] sel_srcaddr;
  logic [DW-1:0] sel_data;

  int unsigned   scan_idx;
`ifdef UMI_REQ_ARB_QOS_EN
  logic [QW-1:0] best_qos;
  logic [QW-1:0] cur_qos;
`endif

  assign slot_free = ~out_valid | out_ready;
  assign eligible  = in_valid & ~arb_mask;

  // Pick the port allowed to drive the slot: the owner while locked,
  // otherwise a round-robin (optionally QoS-first) scan from rr_ptr.
  always_comb begin
    sel      = owner;
    sel_vld  = 1'b0;
    scan_idx = 0;
`ifdef UMI_REQ_ARB_QOS_EN
    best_qos = '0;
    cur_qos  = '0;
`endif
    if (lock) begin
      sel     = owner;
      sel_vld = 1'b1;
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        scan_idx = 32'(rr_ptr) + k;
        if (scan_idx >= N) scan_idx = scan_idx - N;
`ifdef UMI_REQ_ARB_QOS_EN
        cur_qos = in_cmd[scan_idx*CW + QOS_LSB +: QW];
        // Strictly greater keeps the earliest port in scan order on ties.
        if (eligible[scan_idx] && (!sel_vld || (cur_qos > best_qos))) begin
          sel      = IW'(scan_idx);
          sel_vld  = 1'b1;
          best_qos = cur_qos;
        end
`else
        if (!sel_vld && eligible[scan_idx]) begin
          sel     = IW'(scan_idx);
          sel_vld = 1'b1;
        end
`endif
      end
    end
  end

  // Route the selected port's payload toward the output register.
  always_comb begin
    sel_cmd     = '0;
    sel_dstaddr = '0;
    sel_srcaddr = '0;
    sel_data    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel == IW'(i)) begin
        sel_cmd     = in_cmd[i*CW +: CW];
        sel_dstaddr = in_dstaddr[i*AW +: AW];
        sel_srcaddr = in_srcaddr[i*AW +: AW];
        sel_data    = in_data[i*DW +: DW];
      end
    end
  end

  // Ready is one-hot on the selected port and ignores that port's valid.
  always_comb begin
    in_ready = '0;
    if (!reset && slot_free && sel_vld) in_ready[sel] = 1'b1;
  end

  assign accept   = |(in_valid & in_ready);
  assign sel_eom  = sel_cmd[EOM_BIT];
  assign sel_next = (sel == IW'(N - 1)) ? '0 : sel + IW'(1);

  // Output stage: load on acceptance, drain when the slot frees with no beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_cmd     <= '0;
      out_dstaddr <= '0;
      out_srcaddr <= '0;
      out_data    <= '0;
      out_grant   <= '0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_cmd     <= sel_cmd;
      out_dstaddr <= sel_dstaddr;
      out_srcaddr <= sel_srcaddr;
      out_data    <= sel_data;
      out_grant   <= in_ready;
    end else if (slot_free) begin
      out_valid   <= 1'b0;
      out_grant   <= '0;
    end
  end

  // Packet lock and round-robin pointer update on each accepted beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock   <= 1'b0;
      owner  <= '0;
      rr_ptr <= '0;
    end else if (accept) begin
      if (sel_eom) begin
        lock   <= 1'b0;
        rr_ptr <= sel_next;
      end else begin
        lock   <= 1'b1;
        owner  <= sel;
      end
    end
  end

endmodule

// File: tb/tb_umi_req_arbiter.sv
// Self-checking bench for umi_req_arbiter: directed scenarios followed by a
// long randomized run, every cycle compared against a behavioural model.
module tb_umi_req_arbiter;

  localparam int N  = 4;
  localparam int CW = 32;
  localparam int AW = 64;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    in_valid;
  logic [N*CW-1:0] in_cmd;
  logic [N*AW-1:0] in_dstaddr;
  logic [N*AW-1:0] in_srcaddr;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic [N-1:0]    arb_mask;
  logic            out_valid;
  logic [CW-1:0]   out_cmd;
  logic [AW-1:0]   out_dstaddr;
  logic [AW-1:0]   out_srcaddr;
  logic [DW-1:0]   out_data;
  logic            out_ready;
  logic [N-1:0]    out_grant;

  umi_req_arbiter #(.N(N), .CW(CW), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_cmd(in_cmd), .in_dstaddr(in_dstaddr),
    .in_srcaddr(in_srcaddr), .in_data(in_data), .in_ready(in_ready),
    .arb_mask(arb_mask),
    .out_valid(out_valid), .out_cmd(out_cmd), .out_dstaddr(out_dstaddr),
    .out_srcaddr(out_srcaddr), .out_data(out_data), .out_ready(out_ready),
    .out_grant(out_grant)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: packet lock, owner, round-robin start and the output slot.
  bit            m_lock;
  int            m_owner;
  int            m_rr;
  bit            m_ov;
  logic [CW-1:0] m_cmd;
  logic [AW-1:0] m_dst;
  logic [AW-1:0] m_src;
  logic [DW-1:0] m_data;
  int            m_gport;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int port_qos(input int p);
`ifdef UMI_REQ_ARB_QOS_EN
    logic [CW-1:0] c;
    c = in_cmd[p*CW +: CW];
    return int'(c[19:16]);
`else
    return p - p;
`endif
  endfunction

  function automatic bit port_elig(input int p);
    return in_valid[p] && !arb_mask[p];
  endfunction

  // Highest QoS among eligible ports, then the first holder of it from m_rr.
  function automatic void pick(output int s, output bit v);
    int best;
    best = -1;
    s    = 0;
    v    = 1'b0;
    for (int p = 0; p < N; p++)
      if (port_elig(p) && port_qos(p) > best) best = port_qos(p);
    for (int k = 0; k < N; k++) begin
      int p;
      p = (m_rr + k) % N;
      if (!v && port_elig(p) && port_qos(p) == best) begin
        s = p;
        v = 1'b1;
      end
    end
  endfunction

  // One clock: compare at negedge+1, then advance the model across posedge.
  task automatic step();
    int         s;
    bit         v;
    bit         sf;
    bit         acc;
    logic [N-1:0] exp_rdy;
    logic [CW-1:0] c;
    #1;
    sf = !m_ov || out_ready;
    if (m_lock) begin
      s = m_owner;
      v = 1'b1;
    end else begin
      pick(s, v);
    end
    exp_rdy = '0;
    if (!reset && sf && v) exp_rdy[s] = 1'b1;
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    check("out_valid", 64'(out_valid), 64'(m_ov));
    if (m_ov) begin
      check("out_grant", 64'(out_grant), 64'(1) << m_gport);
      check("out_cmd", 64'(out_cmd), 64'(m_cmd));
      check("out_dstaddr", out_dstaddr, m_dst);
      check("out_srcaddr", out_srcaddr, m_src);
      check("out_data", out_data, m_data);
    end
    acc = !reset && sf && v && in_valid[s];
    c   = in_cmd[s*CW +: CW];
    @(posedge clk);
    if (reset) begin
      m_lock = 1'b0; m_owner = 0; m_rr = 0; m_ov = 1'b0;
    end else if (acc) begin
      m_ov    = 1'b1;
      m_gport = s;
      m_cmd   = c;
      m_dst   = in_dstaddr[s*AW +: AW];
      m_src   = in_srcaddr[s*AW +: AW];
      m_data  = in_data[s*DW +: DW];
      if (c[22]) begin
        m_lock = 1'b0;
        m_rr   = (s + 1) % N;
      end else begin
        m_lock  = 1'b1;
        m_owner = s;
      end
    end else if (sf) begin
      m_ov = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic rand_payload();
    for (int w = 0; w < N*CW/32; w++) in_cmd[w*32 +: 32] = $urandom();
    for (int w = 0; w < N*AW/32; w++) begin
      in_dstaddr[w*32 +: 32] = $urandom();
      in_srcaddr[w*32 +: 32] = $urandom();
    end
    for (int w = 0; w < N*DW/32; w++) in_data[w*32 +: 32] = $urandom();
  endtask

  task automatic set_eom_all(input bit eom);
    for (int p = 0; p < N; p++) in_cmd[p*CW + 22] = eom;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = '0; arb_mask = '0; out_ready = 1'b1;
    in_cmd = '0; in_dstaddr = '0; in_srcaddr = '0; in_data = '0;
    m_lock = 1'b0; m_owner = 0; m_rr = 0; m_ov = 1'b0; m_gport = 0;
    m_cmd = '0; m_dst = '0; m_src = '0; m_data = '0;
    @(negedge clk);
    do_reset();
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_out_grant", 64'(out_grant), 64'(0));

    // All ports single-beat: grants rotate 0,1,2,3,0.
    in_valid = '1;
    for (int c = 0; c < 5; c++) begin
      rand_payload();
      set_eom_all(1'b1);
      step();
      check("rr_seq_grant", 64'(out_grant), 64'(1) << (c % N));
    end

    // Ports 0 and 2 masked: only 1 and 3 alternate.
    do_reset();
    arb_mask = 4'b0101;
    for (int c = 0; c < 4; c++) begin
      rand_payload();
      set_eom_all(1'b1);
      step();
      check("mask_grant", 64'(out_grant), (c % 2 == 0) ? 64'h2 : 64'h8);
    end
    arb_mask = '0;

    // QoS: port 0 QoS 2 vs port 2 QoS 9.
    do_reset();
    rand_payload();
    set_eom_all(1'b1);
    in_valid = 4'b0101;
    in_cmd[0*CW + 16 +: 4] = 4'd2;
    in_cmd[2*CW + 16 +: 4] = 4'd9;
    step();
`ifdef UMI_REQ_ARB_QOS_EN
    check("qos_grant", 64'(out_grant), 64'h4);
`else
    check("qos_grant", 64'(out_grant), 64'h1);
`endif

    // Randomized traffic with multi-beat packets, masking, stalls, resets.
    for (int c = 0; c < 3000; c++) begin
      rand_payload();
      for (int p = 0; p < N; p++) begin
        in_valid[p] = ($urandom_range(0, 99) < 70);
        in_cmd[p*CW + 22] = ($urandom_range(0, 99) < 40);
      end
      arb_mask  = ($urandom_range(0, 99) < 20) ? N'($urandom()) : '0;
      out_ready = ($urandom_range(0, 99) < 70);
      reset     = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
